// File: rtl/user_io_bank.sv
// Bank of NUM_IO bidirectional user I/O channels: input sync, edge pulses, registered
// outputs and a turnaround-guarded direction mask. Define USER_IO_DEBOUNCE_EN for input debounce.
module user_io_bank #(
  parameter int NUM_IO      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 4,
  parameter int DEB_CYC     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oeb,
  output logic [NUM_IO-1:0] usr_in,
  output logic [NUM_IO-1:0] usr_rise,
  output logic [NUM_IO-1:0] usr_fall,
  input  logic [NUM_IO-1:0] usr_out,
  input  logic [NUM_IO-1:0] usr_oe,
  input  logic              cfg_dir_valid,
  input  logic [NUM_IO-1:0] cfg_dir_data,
  output logic              cfg_dir_ready
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("user_io_bank: SYNC_STAGES must be at least 2");
  end
  if (DEB_CYC < 1) begin : g_bad_deb
    $error("user_io_bank: DEB_CYC must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  // Without debounce the usr_in register is itself the last synchroniser stage.
`ifdef USER_IO_DEBOUNCE_EN
  localparam int CHAIN = SYNC_STAGES;
`else
  localparam int CHAIN = SYNC_STAGES - 1;
`endif

  logic [NUM_IO-1:0] sync_q [CHAIN];
  logic [NUM_IO-1:0] synced;
  logic [NUM_IO-1:0] usr_in_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHAIN; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < CHAIN; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[CHAIN-1];

`ifdef USER_IO_DEBOUNCE_EN
  localparam int DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam logic [DW-1:0] DEB_TERM = DW'(DEB_CYC - 1);

  logic [DW-1:0] deb_cnt_q [NUM_IO];

  // Counter holds the number of consecutive disagreeing cycles already seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IO; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (synced[i] == usr_in[i] || deb_cnt_q[i] == DEB_TERM) begin
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    usr_in_d = usr_in;
    for (int i = 0; i < NUM_IO; i++) begin
      if (synced[i] != usr_in[i] && deb_cnt_q[i] == DEB_TERM) usr_in_d[i] = synced[i];
    end
  end
`else
  assign usr_in_d = synced;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      usr_in   <= '0;
      usr_rise <= '0;
      usr_fall <= '0;
    end else begin
      usr_in   <= usr_in_d;
      usr_rise <= usr_in_d & ~usr_in;
      usr_fall <= ~usr_in_d & usr_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Direction FSM
  //   state | meaning
  //   IDLE  | drive_en stable, new mask may be accepted
  //   TURN  | bus turnaround: newly enabled channels wait, mask offers held off
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, TURN} state_t;

  localparam int TW = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC);
  localparam logic [TW-1:0] TURN_LOAD = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit HAS_TURN = (TURN_CYC > 0);

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUM_IO-1:0] mask_q, mask_d;
  logic [NUM_IO-1:0] drive_en_q, drive_en_d;
  logic              accept;

  assign accept = cfg_dir_valid & cfg_dir_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    drive_en_d = drive_en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Releases take effect at once; only newly enabled channels wait.
          if (HAS_TURN && |(cfg_dir_data & ~drive_en_q)) begin
            drive_en_d = drive_en_q & cfg_dir_data;
            mask_d     = cfg_dir_data;
            cnt_d      = TURN_LOAD;
            state_d    = TURN;
          end else begin
            drive_en_d = cfg_dir_data;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          drive_en_d = mask_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mask_q        <= '0;
      drive_en_q    <= '0;
      cfg_dir_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      drive_en_q    <= drive_en_d;
      cfg_dir_ready <= (state_d == IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_out <= '0;
      pad_oeb <= '1;
    end else begin
      pad_out <= usr_out;
      pad_oeb <= ~(usr_oe & drive_en_q);
    end
  end

endmodule

// File: tb/tb_user_io_bank.sv
// Randomised bench for user_io_bank against a cycle-timeline reference model;
// honours USER_IO_DEBOUNCE_EN when defined.
module tb_user_io_bank;
  localparam int NUM_IO      = 24;
  localparam int SYNC_STAGES = 2;
  localparam int TURN_CYC    = 4;
  localparam int DEB_CYC     = 16;
`ifdef USER_IO_DEBOUNCE_EN
  localparam int IN_DLY   = SYNC_STAGES;
  localparam int IN_LAT   = SYNC_STAGES + DEB_CYC;
  localparam int FLIP_DIV = 40;
`else
  localparam int IN_DLY   = SYNC_STAGES - 1;
  localparam int IN_LAT   = SYNC_STAGES;
  localparam int FLIP_DIV = 12;
`endif

  logic              clk;
  logic              rst;
  logic [NUM_IO-1:0] pad_in, pad_out, pad_oeb;
  logic [NUM_IO-1:0] usr_in, usr_rise, usr_fall, usr_out, usr_oe;
  logic              cfg_dir_valid, cfg_dir_ready;
  logic [NUM_IO-1:0] cfg_dir_data;

  user_io_bank #(
    .NUM_IO(NUM_IO), .SYNC_STAGES(SYNC_STAGES), .TURN_CYC(TURN_CYC), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oeb(pad_oeb),
    .usr_in(usr_in), .usr_rise(usr_rise), .usr_fall(usr_fall),
    .usr_out(usr_out), .usr_oe(usr_oe),
    .cfg_dir_valid(cfg_dir_valid), .cfg_dir_data(cfg_dir_data), .cfg_dir_ready(cfg_dir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [NUM_IO-1:0] got, input logic [NUM_IO-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs after each edge, derived from input history.
  logic [NUM_IO-1:0] m_out, m_oeb, m_in, m_rise, m_fall;
  logic              m_rdy = 1'b0;
  logic [NUM_IO-1:0] m_de, m_target;
  bit                m_pending = 0;
  int                m_apply = 0;
  int                m_edge = 0;
  logic [NUM_IO-1:0] m_hist[$];
  int                m_run[NUM_IO];

  task automatic model_step();
    logic [NUM_IO-1:0] sv, prev;
    if (rst) begin
      m_out = '0; m_oeb = '1; m_in = '0; m_rise = '0; m_fall = '0;
      m_rdy = 1'b0; m_de = '0; m_pending = 0;
      m_hist.delete();
      for (int i = 0; i < IN_DLY; i++) m_hist.push_back('0);
      for (int i = 0; i < NUM_IO; i++) m_run[i] = 0;
    end else begin
      m_out = usr_out;
      m_oeb = ~(usr_oe & m_de);
      if (m_pending && m_edge == m_apply) begin
        m_de = m_target;
        m_pending = 0;
      end
      if (cfg_dir_valid && m_rdy) begin
        if (TURN_CYC > 0 && (cfg_dir_data & ~m_de) != '0) begin
          m_de      = m_de & cfg_dir_data;
          m_target  = cfg_dir_data;
          m_apply   = m_edge + TURN_CYC;
          m_pending = 1;
        end else begin
          m_de = cfg_dir_data;
        end
      end
      m_rdy = !m_pending;
      prev = m_in;
      sv = m_hist.pop_front();
      m_hist.push_back(pad_in);
`ifdef USER_IO_DEBOUNCE_EN
      for (int i = 0; i < NUM_IO; i++) begin
        if (sv[i] != m_in[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB_CYC) begin
            m_in[i] = sv[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`else
      m_in = sv;
`endif
      m_rise = m_in & ~prev;
      m_fall = ~m_in & prev;
    end
    m_edge++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pad_out", pad_out, m_out);
    check("pad_oeb", pad_oeb, m_oeb);
    check("usr_in", usr_in, m_in);
    check("usr_rise", usr_rise, m_rise);
    check("usr_fall", usr_fall, m_fall);
    check("cfg_dir_ready", cfg_dir_ready, m_rdy);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_dir_ready && n < 50) begin
      tick();
      n++;
    end
    check("wait_ready", cfg_dir_ready, 1'b1);
  endtask

  // Returns after the accepting edge.
  task automatic offer(input logic [NUM_IO-1:0] mask);
    wait_ready();
    cfg_dir_valid = 1'b1;
    cfg_dir_data  = mask;
    tick();
    cfg_dir_valid = 1'b0;
  endtask

  task automatic measure_in(input int ch, input logic lvl, input string tag);
    int lat = 0;
    for (int k = 1; k <= IN_LAT + 8 && lat == 0; k++) begin
      tick();
      if (usr_in[ch] === lvl) begin
        lat = k;
        check({tag, "_pulse"}, lvl ? usr_rise[ch] : usr_fall[ch], 1'b1);
      end
    end
    check({tag, "_lat"}, NUM_IO'(lat), NUM_IO'(IN_LAT));
    tick();
    check({tag, "_pulse_end"}, lvl ? usr_rise[ch] : usr_fall[ch], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lowcnt, lat;
    logic [NUM_IO-1:0] fl, last_mask;
    rst = 1'b1; pad_in = '0; usr_out = '0; usr_oe = '1;
    cfg_dir_valid = 1'b0; cfg_dir_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("ready_after_rst", cfg_dir_ready, 1'b1);
    check("oeb_after_rst", pad_oeb, '1);

    pad_in[5] = 1'b1;
    measure_in(5, 1'b1, "rise5");
    repeat (3) tick();
    pad_in[5] = 1'b0;
    measure_in(5, 1'b0, "fall5");

`ifdef USER_IO_DEBOUNCE_EN
    pad_in[3] = 1'b1;
    repeat (10) tick();
    pad_in[3] = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (usr_in[3] || usr_rise[3]) lat++;
    end
    check("glitch3", NUM_IO'(lat), '0);
    pad_in[3] = 1'b1;
    measure_in(3, 1'b1, "deb3");
`endif

    // Newly enabled channel waits through the turnaround.
    offer(24'h000001);
    lowcnt = cfg_dir_ready ? 0 : 1;
    lat = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (!cfg_dir_ready) lowcnt++;
      if (!pad_oeb[0] && lat == 0) lat = k + 1;
    end
    check("turn_ready_low", NUM_IO'(lowcnt), NUM_IO'(TURN_CYC));
    check("turn_oeb_lat", NUM_IO'(lat), NUM_IO'(TURN_CYC + 2));

    // Release is immediate, no turnaround.
    offer(24'h000003);
    repeat (2) tick();
    offer(24'h000002);
    check("rel_oeb0_hold", pad_oeb[0], 1'b0);
    tick();
    check("rel_oeb0", pad_oeb[0], 1'b1);
    check("rel_oeb1", pad_oeb[1], 1'b0);
    check("rel_no_turn", cfg_dir_ready, 1'b1);

    offer(24'h000002);
    check("same_mask_ready", cfg_dir_ready, 1'b1);
    tick();
    check("same_mask_oeb", pad_oeb[1:0], 2'b01);

    // Reset in the middle of a turnaround.
    offer(24'h000012);
    tick();
    rst = 1'b1;
    tick();
    check("rst_turn_oeb", pad_oeb, '1);
    check("rst_turn_ready", cfg_dir_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_turn_idle", cfg_dir_ready, 1'b1);
    check("rst_turn_de", pad_oeb, '1);

    last_mask = '0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(249) == 0);
      for (int i = 0; i < NUM_IO; i++) fl[i] = ($urandom_range(FLIP_DIV - 1) == 0);
      pad_in  = pad_in ^ fl;
      usr_out = NUM_IO'($urandom);
      usr_oe  = ($urandom_range(3) == 0) ? NUM_IO'($urandom) : '1;
      cfg_dir_valid = ($urandom_range(3) == 0);
      case ($urandom_range(2))
        0: cfg_dir_data = NUM_IO'($urandom);
        1: cfg_dir_data = last_mask;
        default: cfg_dir_data = last_mask & NUM_IO'($urandom);
      endcase
      if (cfg_dir_valid) last_mask = cfg_dir_data;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
